// File: rtl/bp_nonsynth_if_pkg.sv
// bp_nonsynth_if_pkg: error codes, channel FSM states and beat-count helper for the BedRock stream checker
package bp_nonsynth_if_pkg;
  typedef enum logic [2:0] {
    e_err_none      = 3'd0,
    e_err_v_drop    = 3'd1,
    e_err_hold_chg  = 3'd2,
    e_err_hdr_chg   = 3'd3,
    e_err_last      = 3'd4,
    e_err_timeout   = 3'd5,
    e_err_outst_udf = 3'd6,
    e_err_outst_ovf = 3'd7
  } bp_stream_err_e;
  typedef enum logic [1:0] {e_idle, e_hold, e_stream} bp_stream_state_e;
  function automatic int unsigned bp_stream_beats(input logic [2:0] size, input int unsigned data_width);
    int unsigned bits;
    bits = (32'd1 << size) * 32'd8;
    return (bits > data_width) ? bits / data_width : 32'd1;
  endfunction
endpackage

// File: rtl/bp_nonsynth_stream_chan_checker.sv
// bp_nonsynth_stream_chan_checker: per-channel handshake/header/length/stall checker with sticky first-error latch
// BP_NONSYNTH_STREAM_CHECKER_FATAL_EN makes every detected error end the simulation.
module bp_nonsynth_stream_chan_checker
  import bp_nonsynth_if_pkg::*;
#(
  parameter int chan_p         = 0,
  parameter int header_width_p = 128,
  parameter int data_width_p   = 64,
  parameter int size_lsb_p     = 0,
  parameter int timeout_p      = 1024
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [header_width_p-1:0] i_header,
  input  logic [data_width_p-1:0]   i_data,
  input  logic                      i_v,
  input  logic                      i_ready_and,
  input  logic                      i_last,
  input  logic                      i_outst_udf,
  input  logic                      i_outst_ovf,
  output logic                      o_done,
  output logic                      o_error,
  output logic [2:0]                o_err_code,
  output logic [31:0]               o_msg_count
);
  localparam int sw_lp = $clog2(timeout_p + 1);
  localparam logic [sw_lp-1:0] tmax_lp = sw_lp'(timeout_p);
  localparam logic [sw_lp-1:0] tlast_lp = sw_lp'(timeout_p - 1);
`ifdef BP_NONSYNTH_STREAM_CHECKER_FATAL_EN
  localparam bit fatal_lp = 1'b1;
`else
  localparam bit fatal_lp = 1'b0;
`endif
  bp_stream_state_e r_state, w_state_n;
  bp_stream_err_e w_err;
  logic [header_width_p-1:0] r_hdr, w_hdr_ref;
  logic [data_width_p-1:0] r_data;
  logic [7:0] r_beat_cnt, w_beat_idx;
  logic [sw_lp-1:0] r_stall;
  logic [31:0] r_msg_count;
  logic [2:0] r_err_code;
  logic r_error, w_hs, w_stall, w_final, w_timeout;
  int unsigned w_beats;
  assign w_hs = i_v & i_ready_and;
  assign w_stall = i_v & ~i_ready_and;
  // beat count comes from the live header only on the first beat, afterwards from the captured one
  assign w_hdr_ref = (r_state == e_idle) ? i_header : r_hdr;
  assign w_beats = bp_stream_beats(w_hdr_ref[size_lsb_p +: 3], data_width_p);
  assign w_beat_idx = (r_state == e_stream) ? r_beat_cnt : 8'd0;
  assign w_final = w_hs && ({24'd0, w_beat_idx} + 32'd1 == w_beats);
  assign w_timeout = w_stall && (r_stall == tlast_lp);
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= e_idle;
      r_hdr       <= '0;
      r_data      <= '0;
      r_beat_cnt  <= '0;
      r_stall     <= '0;
      r_msg_count <= '0;
      r_error     <= 1'b0;
      r_err_code  <= '0;
    end else begin
      r_state <= w_state_n;
      if (r_state == e_idle && i_v) begin
        r_hdr  <= i_header;
        r_data <= i_data;
      end
      if (w_hs) r_beat_cnt <= w_final ? 8'd0 : w_beat_idx + 8'd1;
      r_stall <= !w_stall ? '0 : (r_stall == tmax_lp) ? r_stall : r_stall + 1'b1;
      r_msg_count <= r_msg_count + {31'd0, w_final};
      if (!r_error && w_err != e_err_none) begin
        r_error    <= 1'b1;
        r_err_code <= w_err;
      end
      if (w_err != e_err_none) begin
        $display("[%0t] bp_stream_checker chan %0d error code %0d", $time, chan_p, w_err);
        if (fatal_lp) $fatal(1, "bp_stream_checker chan %0d error code %0d", chan_p, w_err);
      end
    end
  end
  // stream only exits on the final beat; from idle/hold a stall parks, a multi-beat handshake streams
  always_comb begin
    w_state_n = (r_state == e_stream) ? (w_final ? e_idle : e_stream)
              : w_stall ? e_hold : (w_hs && !w_final) ? e_stream : e_idle;
  end
  always_comb begin
    w_err = (r_state == e_hold && !i_v) ? e_err_v_drop
          : (r_state == e_hold && (i_header != r_hdr || i_data != r_data)) ? e_err_hold_chg
          : (r_state == e_stream && w_hs && i_header != r_hdr) ? e_err_hdr_chg
          : (w_hs && (i_last != w_final)) ? e_err_last
          : w_timeout ? e_err_timeout
          : i_outst_udf ? e_err_outst_udf
          : i_outst_ovf ? e_err_outst_ovf : e_err_none;
  end
  assign o_done = w_final;
  assign o_error = r_error;
  assign o_err_code = r_err_code;
  assign o_msg_count = r_msg_count;
endmodule

// File: rtl/bp_nonsynth_bedrock_stream_checker.sv
// bp_nonsynth_bedrock_stream_checker: runtime protocol checker for num_chan_p BedRock ready/valid streams
// plus request/response outstanding balance; BP_NONSYNTH_STREAM_CHECKER_FATAL_EN turns errors fatal.
module bp_nonsynth_bedrock_stream_checker
  import bp_nonsynth_if_pkg::*;
#(
  parameter int num_chan_p        = 2,
  parameter int header_width_p    = 128,
  parameter int data_width_p      = 64,
  parameter int size_lsb_p        = 0,
  parameter int paired_p          = 1,
  parameter int max_outstanding_p = 8,
  parameter int timeout_p         = 1024
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_chan_p*header_width_p-1:0] header_i,
  input  logic [num_chan_p*data_width_p-1:0]   data_i,
  input  logic [num_chan_p-1:0]                v_i,
  input  logic [num_chan_p-1:0]                ready_and_i,
  input  logic [num_chan_p-1:0]                last_i,
  output logic [num_chan_p-1:0]                error_o,
  output logic [num_chan_p*3-1:0]              err_code_o,
  output logic [num_chan_p*32-1:0]             msg_count_o
);
  localparam int ow_lp = $clog2(max_outstanding_p + 1);
  localparam logic [ow_lp-1:0] omax_lp = ow_lp'(max_outstanding_p);
  logic [num_chan_p-1:0] w_done, w_udf, w_ovf;
  for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
    bp_nonsynth_stream_chan_checker #(
      .chan_p(c), .header_width_p(header_width_p), .data_width_p(data_width_p),
      .size_lsb_p(size_lsb_p), .timeout_p(timeout_p)
    ) u_chan (
      .clk_i, .reset_i,
      .i_header(header_i[c*header_width_p +: header_width_p]),
      .i_data(data_i[c*data_width_p +: data_width_p]),
      .i_v(v_i[c]), .i_ready_and(ready_and_i[c]), .i_last(last_i[c]),
      .i_outst_udf(w_udf[c]), .i_outst_ovf(w_ovf[c]),
      .o_done(w_done[c]), .o_error(error_o[c]),
      .o_err_code(err_code_o[c*3 +: 3]), .o_msg_count(msg_count_o[c*32 +: 32])
    );
  end
  if (paired_p != 0) begin : g_pair
    for (genvar p = 0; p < num_chan_p / 2; p++) begin : g_p
      logic [ow_lp-1:0] r_outst;
      logic w_inc, w_dec;
      // simultaneous request and response completions cancel out
      assign w_inc = w_done[2*p] & ~w_done[2*p+1];
      assign w_dec = w_done[2*p+1] & ~w_done[2*p];
      assign w_ovf[2*p] = w_inc && (r_outst == omax_lp);
      assign w_udf[2*p] = 1'b0;
      assign w_ovf[2*p+1] = 1'b0;
      assign w_udf[2*p+1] = w_dec && (r_outst == '0);
      always_ff @(posedge clk_i) begin
        if (reset_i) r_outst <= '0;
        else if (w_inc && r_outst != omax_lp) r_outst <= r_outst + 1'b1;
        else if (w_dec && r_outst != '0) r_outst <= r_outst - 1'b1;
      end
    end
    if (num_chan_p % 2 != 0) begin : g_odd
      assign w_ovf[num_chan_p-1] = 1'b0;
      assign w_udf[num_chan_p-1] = 1'b0;
    end
  end else begin : g_unpaired
    assign w_ovf = '0;
    assign w_udf = '0;
  end
endmodule
